// File: rtl/grad_playback_scheduler.sv
// grad_playback_scheduler: BRAM-to-SPI gradient sample sequencer with LDAC timing; define GRAD_SCHED_LOOP_EN to enable looped playback
module grad_playback_scheduler #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int DIV_WIDTH       = 16,
  parameter int LDAC_CYCLES     = 3
)(
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       cfg_start,
  input  logic                       cfg_stop,
  input  logic                       cfg_loop,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_base,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_length,
  input  logic [DIV_WIDTH-1:0]       cfg_divider,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  input  logic [23:0]                bram_rddata_x,
  input  logic [23:0]                bram_rddata_y,
  input  logic [23:0]                bram_rddata_z,
  output logic [23:0]                m_data_x,
  output logic [23:0]                m_data_y,
  output logic [23:0]                m_data_z,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic                       ser_done,
  output logic                       ldacn,
  output logic                       sts_busy,
  output logic [BRAM_ADDR_WIDTH-1:0] sts_sample,
  output logic                       sts_underrun
);
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int LW = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, WAIT_DONE, WAIT_TICK, LDAC} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, idx_q, idx_d, base_q, base_d, len_q, len_d, sample_q, sample_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [LW-1:0] lc_q, lc_d;
  logic [23:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic valid_q, valid_d, ldacn_q, ldacn_d, under_q, under_d, stop_q, stop_d, loop_q, loop_d;
  logic busy, tick, loop_en;
  assign busy = state_q != IDLE;
  assign tick = busy && cnt_q == div_q;
`ifdef GRAD_SCHED_LOOP_EN
  assign loop_en = loop_q;
`else
  assign loop_en = loop_q & 1'b0;
`endif
  assign bram_addr    = addr_q;
  assign m_data_x     = x_q;
  assign m_data_y     = y_q;
  assign m_data_z     = z_q;
  assign m_valid      = valid_q;
  assign ldacn        = ldacn_q;
  assign sts_busy     = busy;
  assign sts_sample   = sample_q;
  assign sts_underrun = under_q;
  // next-state: playback sequencing, tick counter, stop/underrun tracking
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    base_d   = base_q;
    len_d    = len_q;
    div_d    = div_q;
    loop_d   = loop_q;
    sample_d = sample_q;
    lc_d     = lc_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    valid_d  = valid_q;
    ldacn_d  = ldacn_q;
    cnt_d    = busy ? (tick ? '0 : cnt_q + DIV_WIDTH'(1)) : '0;
    under_d  = under_q | (tick && state_q != WAIT_TICK);
    stop_d   = busy & (stop_q | cfg_stop);
    case (state_q)
      IDLE: if (cfg_start && !cfg_stop) begin
        state_d = FETCH;
        addr_d  = cfg_base;
        idx_d   = '0;
        base_d  = cfg_base;
        len_d   = cfg_length;
        div_d   = cfg_divider;
        loop_d  = cfg_loop;
        under_d = 1'b0;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        x_d     = bram_rddata_x;
        y_d     = bram_rddata_y;
        z_d     = bram_rddata_z;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (m_ready) begin
        valid_d = 1'b0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: state_d = ser_done ? WAIT_TICK : WAIT_DONE;
      WAIT_TICK: if (tick) begin
        ldacn_d = 1'b0;
        lc_d    = '0;
        state_d = LDAC;
      end
      LDAC: if (lc_q == LW'(LDAC_CYCLES - 1)) begin
        ldacn_d  = 1'b1;
        sample_d = idx_q;
        if (stop_q || cfg_stop) state_d = IDLE;
        else if (idx_q == len_q) begin
          state_d = loop_en ? FETCH : IDLE;
          addr_d  = loop_en ? base_q : addr_q;
          idx_d   = loop_en ? '0 : idx_q;
        end else begin
          state_d = FETCH;
          addr_d  = addr_q + AW'(1);
          idx_d   = idx_q + AW'(1);
        end
      end else lc_d = lc_q + LW'(1);
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      div_q    <= '0;
      loop_q   <= 1'b0;
      sample_q <= '0;
      lc_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      valid_q  <= 1'b0;
      ldacn_q  <= 1'b1;
      cnt_q    <= '0;
      under_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      len_q    <= len_d;
      div_q    <= div_d;
      loop_q   <= loop_d;
      sample_q <= sample_d;
      lc_q     <= lc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      valid_q  <= valid_d;
      ldacn_q  <= ldacn_d;
      cnt_q    <= cnt_d;
      under_q  <= under_d;
      stop_q   <= stop_d;
    end
  end
endmodule

// File: tb/tb_grad_playback_scheduler.sv
// tb_grad_playback_scheduler: directed vector bench with BRAM and serializer models
module tb_grad_playback_scheduler;
`ifdef GRAD_SCHED_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn, cfg_start, cfg_stop, cfg_loop;
  logic [9:0] cfg_base, cfg_length, bram_addr, sts_sample;
  logic [15:0] cfg_divider;
  logic [23:0] rd_x, rd_y, rd_z, m_data_x, m_data_y, m_data_z;
  logic m_valid, m_ready, ser_done, ldacn, sts_busy, sts_underrun;

  grad_playback_scheduler dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_loop(cfg_loop), .cfg_base(cfg_base), .cfg_length(cfg_length),
    .cfg_divider(cfg_divider), .bram_addr(bram_addr), .bram_rddata_x(rd_x),
    .bram_rddata_y(rd_y), .bram_rddata_z(rd_z), .m_data_x(m_data_x),
    .m_data_y(m_data_y), .m_data_z(m_data_z), .m_valid(m_valid), .m_ready(m_ready),
    .ser_done(ser_done), .ldacn(ldacn), .sts_busy(sts_busy), .sts_sample(sts_sample),
    .sts_underrun(sts_underrun)
  );

  typedef struct {
    logic [9:0]  base;
    logic [9:0]  len;
    logic [15:0] div;
    logic        loop;
    int          hold;
    int          frame;
    int          exp_pulses;
    int          exp_first;
    int          exp_space;
    logic [9:0]  exp_sample;
    logic        exp_under;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  int ser_hold = 0, ser_frame = 20, stab_err = 0;
  logic [71:0] sent_q[$];
  int fall_q[$], width_q[$], vcyc_q[$];

  function automatic logic [71:0] exp_word(input logic [9:0] a);
    return {24'hA00000 | {14'b0, a}, 24'hB00000 | {14'b0, a}, 24'hC00000 | {14'b0, a}};
  endfunction

  always @(posedge aclk) begin
    cyc  <= cyc + 1;
    rd_x <= 24'hA00000 | {14'b0, bram_addr};
    rd_y <= 24'hB00000 | {14'b0, bram_addr};
    rd_z <= 24'hC00000 | {14'b0, bram_addr};
  end

  // serializer: accepts after ser_hold cycles of valid, pulses ser_done ser_frame cycles later
  initial begin
    int sr, vc, fc;
    logic [71:0] hold_data;
    sr = 0; vc = 0; fc = 0; hold_data = '0;
    m_ready = 1'b0; ser_done = 1'b0;
    forever begin
      @(posedge aclk); #1;
      ser_done = 1'b0;
      if (!aresetn) begin
        sr = 0; vc = 0; fc = 0; m_ready = 1'b0;
      end else if (sr == 0) begin
        if (m_valid) begin
          vc++;
          if (vc == 1) begin
            hold_data = {m_data_x, m_data_y, m_data_z};
            vcyc_q.push_back(cyc);
          end else if ({m_data_x, m_data_y, m_data_z} !== hold_data) stab_err++;
          if (vc > ser_hold) begin m_ready = 1'b1; sr = 1; end
        end
      end else if (sr == 1) begin
        sent_q.push_back({m_data_x, m_data_y, m_data_z});
        if (m_valid) stab_err++;
        m_ready = 1'b0; vc = 0; fc = 0; sr = 2;
      end else begin
        fc++;
        if (fc >= ser_frame) begin ser_done = 1'b1; sr = 0; end
      end
    end
  end

  // LDAC pulse monitor: falling-edge cycle and low width
  initial begin
    logic prev;
    int lf;
    prev = 1'b1; lf = 0;
    forever begin
      @(posedge aclk); #1;
      if (prev && !ldacn) begin fall_q.push_back(cyc); lf = cyc; end
      if (!prev && ldacn) width_q.push_back(cyc - lf);
      prev = ldacn;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic clear_logs();
    sent_q.delete(); fall_q.delete(); width_q.delete(); vcyc_q.delete(); stab_err = 0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (sts_busy && n < budget) begin @(posedge aclk); #1; n++; end
    check({nm, "_done"}, sts_busy, 0);
    tick_n(3);
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_addr"}, bram_addr, 0);
    check({nm, "_data"}, {m_data_x, m_data_y, m_data_z}, 0);
    check({nm, "_valid"}, m_valid, 0);
    check({nm, "_ldacn"}, ldacn, 1);
    check({nm, "_busy"}, sts_busy, 0);
    check({nm, "_sample"}, sts_sample, 0);
    check({nm, "_under"}, sts_underrun, 0);
  endtask

  task automatic do_start(input logic [9:0] b, input logic [9:0] l, input logic [15:0] d, input logic lp);
    cfg_base = b; cfg_length = l; cfg_divider = d; cfg_loop = lp;
    cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0; t0 = cyc;
    cfg_base = 10'h2AA; cfg_length = 10'd0; cfg_divider = 16'd3; cfg_loop = ~lp;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    clear_logs();
    ser_hold = v.hold; ser_frame = v.frame;
    do_start(v.base, v.len, v.div, v.loop);
    check({nm, "_addr0"}, bram_addr, v.base);
    check({nm, "_busy0"}, sts_busy, 1);
    check({nm, "_under0"}, sts_underrun, 0);
    wait_idle(nm, 20000);
    check({nm, "_pulses"}, fall_q.size(), v.exp_pulses);
    check({nm, "_xfers"}, sent_q.size(), v.exp_pulses);
    check({nm, "_sample"}, sts_sample, v.exp_sample);
    check({nm, "_under"}, sts_underrun, v.exp_under);
    check({nm, "_stable"}, stab_err, 0);
    if (vcyc_q.size() > 0) check({nm, "_valid_lat"}, vcyc_q[0] - t0, 2);
    if (fall_q.size() > 0) check({nm, "_first"}, fall_q[0] - t0, v.exp_first);
    for (int i = 0; i < fall_q.size() && i < width_q.size(); i++) begin
      check($sformatf("%s_width%0d", nm, i), width_q[i], 3);
      if (i > 0) check($sformatf("%s_space%0d", nm, i), fall_q[i] - fall_q[i-1], v.exp_space);
    end
    for (int i = 0; i < sent_q.size(); i++)
      check($sformatf("%s_word%0d", nm, i), sent_q[i], exp_word(v.base + 10'(i)));
  endtask

  initial begin
    vec_t vecs[4];
    logic [9:0] stop_seq[5];
    int nstop, n;
    vecs[0] = '{10'h010, 10'd3, 16'd1429, 1'b0, 0, 200, 4, 1430, 1430, 10'd3, 1'b0};
    vecs[1] = '{10'h005, 10'd2, 16'd99, 1'b0, 0, 150, 3, 200, 200, 10'd2, 1'b1};
    vecs[2] = '{10'h3FE, 10'd2, 16'd299, !LOOP_EN, 0, 20, 3, 300, 300, 10'd2, 1'b0};
    vecs[3] = '{10'h020, 10'd1, 16'd399, 1'b0, 50, 20, 2, 400, 400, 10'd1, 1'b0};
    stop_seq = '{10'h3FE, 10'h3FF, 10'h000, 10'h3FE, 10'h3FF};

    aresetn = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_loop = 1'b0;
    cfg_base = '0; cfg_length = '0; cfg_divider = '0;
    tick_n(3);
    check_reset("reset");
    aresetn = 1'b1;
    tick_n(2);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // stop while 0x3FF is in flight: its LDAC still happens, then no further fetch
    clear_logs();
    ser_hold = 0; ser_frame = 20;
    nstop = LOOP_EN ? 5 : 2;
    do_start(10'h3FE, 10'd2, 16'd299, 1'b1);
    n = 0;
    while (sent_q.size() < nstop && n < 5000) begin tick_n(1); n++; end
    check("stop_reach", sent_q.size(), nstop);
    cfg_stop = 1'b1; tick_n(1); cfg_stop = 1'b0;
    wait_idle("stop", 5000);
    tick_n(20);
    check("stop_pulses", fall_q.size(), nstop);
    check("stop_xfers", sent_q.size(), nstop);
    check("stop_sample", sts_sample, 1);
    check("stop_busy", sts_busy, 0);
    for (int i = 0; i < sent_q.size() && i < 5; i++)
      check($sformatf("stop_word%0d", i), sent_q[i], exp_word(stop_seq[i]));

    // reset while a triplet is held in SEND
    clear_logs();
    ser_hold = 1000;
    do_start(10'h0AB, 10'd0, 16'd999, 1'b0);
    n = 0;
    while (!m_valid && n < 10) begin tick_n(1); n++; end
    tick_n(3);
    check("send_valid", m_valid, 1);
    check("send_data", {m_data_x, m_data_y, m_data_z}, exp_word(10'h0AB));
    aresetn = 1'b0; tick_n(1);
    check_reset("rst_send");
    aresetn = 1'b1; tick_n(2);

    // reset while LDACn is low after an underrun
    clear_logs();
    ser_hold = 0; ser_frame = 20;
    do_start(10'h040, 10'd0, 16'd9, 1'b0);
    n = 0;
    while (ldacn && n < 200) begin tick_n(1); n++; end
    check("ldac_low", ldacn, 0);
    check("ldac_under", sts_underrun, 1);
    aresetn = 1'b0; tick_n(1);
    check_reset("rst_ldac");
    aresetn = 1'b1; tick_n(2);

    // simultaneous start and stop in IDLE: stop wins
    clear_logs();
    cfg_base = 10'h155; cfg_length = 10'd1; cfg_divider = 16'd50;
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick_n(1);
    cfg_start = 1'b0; cfg_stop = 1'b0;
    check("ss_busy", sts_busy, 0);
    check("ss_addr", bram_addr, 0);
    check("ss_ldacn", ldacn, 1);
    tick_n(10);
    check("ss_idle", sts_busy, 0);
    check("ss_valid", m_valid, 0);
    check("ss_xfers", sent_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
